// File: rtl/irq_ack_unit_pkg.sv
// Shared constants, FSM encoding and priority helper for the interrupt acknowledge unit.
package irq_ack_unit_pkg;

    localparam int IRQ_N     = 8;
    localparam int IRQ_NUM_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // Bit 0 is highest priority, so the lowest set index wins.
    function automatic logic [IRQ_NUM_W-1:0] lowest_idx(input logic [IRQ_N-1:0] v);
        logic [IRQ_NUM_W-1:0] idx;
        idx = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (v[i]) idx = IRQ_NUM_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One IRQ line: SYNC_STAGES-flop synchroniser followed by a rising-edge detector.
// Pulse is one cycle wide; history clears on reset so a line high at release counts as an edge.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ack_unit.sv
// Interrupt acknowledge unit: latches IRQ edges, requests the lowest enabled index, one handler at a time.
// Optional IRQ_MASK_EN adds a write-only enable mask; irq edge to int_req is SYNC_STAGES+2 cycles.
module irq_ack_unit
    import irq_ack_unit_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_N-1:0]     irq_in,
`ifdef IRQ_MASK_EN
    input  logic                 mask_wr,
    input  logic [IRQ_N-1:0]     mask_wdata,
`endif
    input  logic                 int_ack,
    input  logic                 eoi,
    output logic                 int_req,
    output logic [IRQ_NUM_W-1:0] int_num,
    output logic                 in_service,
    output logic [IRQ_N-1:0]     pending
);

    logic [IRQ_N-1:0]     rise;
    logic [IRQ_N-1:0]     pending_q, pending_d;
    logic [IRQ_N-1:0]     clr;
    logic [IRQ_N-1:0]     enabled;
    state_e               state_q;
    logic                 int_req_q;
    logic                 in_service_q;
    logic [IRQ_NUM_W-1:0] int_num_q;

    for (genvar g = 0; g < IRQ_N; g++) begin : g_line
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
            .clk    (clk),
            .rst_n  (rst_n),
            .irq_i  (irq_in[g]),
            .rise_o (rise[g])
        );
    end

`ifdef IRQ_MASK_EN
    logic [IRQ_N-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mask_q <= '1;
        else if (mask_wr) mask_q <= mask_wdata;
    end

    assign enabled = pending_q & mask_q;
`else
    assign enabled = pending_q;
`endif

    // A fresh edge on the line being acknowledged wins over the clear.
    always_comb begin
        clr = '0;
        if (state_q == REQ && int_ack) clr[int_num_q] = 1'b1;
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            int_req_q    <= 1'b0;
            int_num_q    <= '0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|enabled) begin
                        int_num_q <= lowest_idx(enabled);
                        int_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_req_q    <= 1'b0;
                        in_service_q <= 1'b1;
                        state_q      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        in_service_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    int_req_q    <= 1'b0;
                    in_service_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign int_req    = int_req_q;
    assign int_num    = int_num_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_irq_ack_unit.sv
// Bench for irq_ack_unit: vector table, directed corner sequences and a randomized run against a reference model.
module tb_irq_ack_unit;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_in = 8'h00;
    logic       int_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       int_req;
    logic [2:0] int_num;
    logic       in_service;
    logic [7:0] pending;
`ifdef IRQ_MASK_EN
    logic       mask_wr = 1'b0;
    logic [7:0] mask_wdata = 8'h00;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_ack_unit #(.SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
`ifdef IRQ_MASK_EN
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
`endif
        .int_ack    (int_ack),
        .eoi        (eoi),
        .int_req    (int_req),
        .int_num    (int_num),
        .in_service (in_service),
        .pending    (pending)
    );

    // Reference model: a sample history per edge, a pending set, and a mode
    // (0 = no request, 1 = waiting for ack, 2 = handler running).
    logic [7:0] hist [SYNC+2];
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    int         m_mode;
    int         m_num;

    task automatic model_reset();
        for (int i = 0; i < SYNC + 2; i++) hist[i] = 8'h00;
        m_pend = 8'h00;
        m_mask = 8'hFF;
        m_mode = 0;
        m_num  = 0;
    endtask

    task automatic model_edge(input logic [7:0] irq, input logic ack, input logic e,
                              input logic mwr, input logic [7:0] mwd);
        logic [7:0] rise, old, clr, en;
        for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = irq;
        // Line seen high SYNC edges ago, low the edge before that.
        rise = hist[SYNC] & ~hist[SYNC+1];
        old  = m_pend;
        clr  = 8'h00;
        if (m_mode == 0) begin
            en = old & m_mask;
            if (en != 8'h00) begin
                m_num = 8;
                for (int i = 0; i < 8; i++) if (en[i] && m_num == 8) m_num = i;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (ack) begin
                clr    = 8'h01 << m_num;
                m_mode = 2;
            end
        end else if (e) begin
            m_mode = 0;
        end
        m_pend = (old & ~clr) | rise;
        if (mwr) m_mask = mwd;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model_req", int'(int_req), (m_mode == 1) ? 1 : 0);
        chk("model_svc", int'(in_service), (m_mode == 2) ? 1 : 0);
        chk("model_pend", int'(pending), int'(m_pend));
        if (m_mode == 1) chk("model_num", int'(int_num), m_num);
    endtask

    // Called at posedge+1: drive, take one edge, update the model, compare.
    task automatic step(input logic [7:0] irq, input logic ack, input logic e);
        logic       mwr;
        logic [7:0] mwd;
        irq_in  = irq;
        int_ack = ack;
        eoi     = e;
        mwr     = 1'b0;
        mwd     = 8'h00;
`ifdef IRQ_MASK_EN
        mwr = mask_wr;
        mwd = mask_wdata;
`endif
        @(posedge clk);
        model_edge(irq, ack, e, mwr, mwd);
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req", int'(int_req), 0);
        chk("rst_num", int'(int_num), 0);
        chk("rst_svc", int'(in_service), 0);
        chk("rst_pend", int'(pending), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] irq;
        logic       ack;
        logic       e;
        logic       req;
        logic [2:0] num;
        logic       svc;
        logic [7:0] pend;
    } vec_t;

    vec_t vt [17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_req", int'(int_req), 0);
        chk("init_svc", int'(in_service), 0);
        chk("init_pend", int'(pending), 0);
        chk("init_num", int'(int_num), 0);
        rst_n = 1'b1;

        // 8'h20 pulse then 8'h90 pair, served in priority order.
        vt[0]  = '{8'h20, 0, 0, 0, 0, 0, 8'h00};
        vt[1]  = '{8'h20, 0, 0, 0, 0, 0, 8'h00};
        vt[2]  = '{8'h00, 0, 0, 0, 0, 0, 8'h20};
        vt[3]  = '{8'h00, 0, 0, 1, 5, 0, 8'h20};
        vt[4]  = '{8'h00, 1, 0, 0, 5, 1, 8'h00};
        vt[5]  = '{8'h00, 1, 0, 0, 5, 1, 8'h00};
        vt[6]  = '{8'h00, 0, 1, 0, 5, 0, 8'h00};
        vt[7]  = '{8'h00, 0, 1, 0, 5, 0, 8'h00};
        vt[8]  = '{8'h90, 0, 0, 0, 5, 0, 8'h00};
        vt[9]  = '{8'h90, 0, 0, 0, 5, 0, 8'h00};
        vt[10] = '{8'h00, 0, 0, 0, 5, 0, 8'h90};
        vt[11] = '{8'h00, 0, 0, 1, 4, 0, 8'h90};
        vt[12] = '{8'h00, 1, 0, 0, 4, 1, 8'h80};
        vt[13] = '{8'h00, 0, 1, 0, 4, 0, 8'h80};
        vt[14] = '{8'h00, 0, 0, 1, 7, 0, 8'h80};
        vt[15] = '{8'h00, 1, 0, 0, 7, 1, 8'h00};
        vt[16] = '{8'h00, 0, 1, 0, 7, 0, 8'h00};

        for (int i = 0; i < 17; i++) begin
            step(vt[i].irq, vt[i].ack, vt[i].e);
            chk($sformatf("vec%0d_req", i), int'(int_req), int'(vt[i].req));
            chk($sformatf("vec%0d_svc", i), int'(in_service), int'(vt[i].svc));
            chk($sformatf("vec%0d_pend", i), int'(pending), int'(vt[i].pend));
            if (vt[i].req) chk($sformatf("vec%0d_num", i), int'(int_num), int'(vt[i].num));
        end

        // Higher priority arriving during REQ must not steal the frozen index.
        repeat (2) step(8'h40, 0, 0);
        step(8'h00, 0, 0);
        step(8'h00, 0, 0);
        chk("prio_req6", int'(int_req), 1);
        chk("prio_num6", int'(int_num), 6);
        repeat (2) step(8'h02, 0, 0);
        repeat (3) begin
            step(8'h00, 0, 0);
            chk("prio_frozen", int'(int_num), 6);
        end
        chk("prio_pend", int'(pending), 8'h42);
        step(8'h00, 1, 0);
        chk("prio_ack_pend", int'(pending), 8'h02);
        step(8'h00, 0, 1);
        step(8'h00, 0, 0);
        chk("prio_req1", int'(int_req), 1);
        chk("prio_num1", int'(int_num), 1);
        step(8'h00, 1, 0);
        step(8'h00, 0, 1);

        // A held level re-arms only after the line drops.
        repeat (4) step(8'h08, 0, 0);
        chk("lvl_req", int'(int_req), 1);
        chk("lvl_num", int'(int_num), 3);
        step(8'h08, 1, 0);
        step(8'h08, 0, 1);
        repeat (6) begin
            step(8'h08, 0, 0);
            chk("lvl_noreq", int'(int_req), 0);
        end
        chk("lvl_pend0", int'(pending), 0);
        repeat (3) step(8'h00, 0, 0);
        repeat (4) step(8'h08, 0, 0);
        chk("lvl_rereq", int'(int_req), 1);
        chk("lvl_renum", int'(int_num), 3);
        step(8'h08, 1, 0);
        step(8'h00, 0, 1);
        repeat (3) step(8'h00, 0, 0);

        // Reset during SERVICE, with line 0 held high through release.
        repeat (4) step(8'h01, 0, 0);
        step(8'h01, 1, 0);
        chk("rs_svc_before", int'(in_service), 1);
        do_reset();
        repeat (4) step(8'h01, 0, 0);
        chk("rs_req", int'(int_req), 1);
        chk("rs_num", int'(int_num), 0);
        step(8'h01, 1, 0);
        step(8'h00, 0, 1);
        repeat (3) step(8'h00, 0, 0);

`ifdef IRQ_MASK_EN
        mask_wr = 1'b1;
        mask_wdata = 8'hFE;
        step(8'h00, 0, 0);
        mask_wr = 1'b0;
        repeat (6) step(8'h01, 0, 0);
        chk("msk_pend", int'(pending[0]), 1);
        chk("msk_noreq", int'(int_req), 0);
        mask_wr = 1'b1;
        mask_wdata = 8'hFF;
        step(8'h00, 0, 0);
        mask_wr = 1'b0;
        step(8'h00, 0, 0);
        chk("msk_req", int'(int_req), 1);
        chk("msk_num", int'(int_num), 0);
        step(8'h00, 1, 0);
        step(8'h00, 0, 1);
`endif

        // Randomized traffic against the model.
        begin
            logic [7:0] r_irq;
            r_irq = 8'h00;
            for (int c = 0; c < 3000; c++) begin
                r_irq = r_irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
`ifdef IRQ_MASK_EN
                mask_wr = ($urandom_range(0, 15) == 0);
                mask_wdata = 8'($urandom) | 8'($urandom);
`endif
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                end else begin
                    step(r_irq, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
                end
            end
`ifdef IRQ_MASK_EN
            mask_wr = 1'b0;
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
